frac_scaler_dda: RTL and testbench

FRAC_SCALER_DDA -- requirements
Module: frac_scaler_dda

---
 rtl/frac_scaler_dda.sv | 254 +++++++++++++++++++++++++
 tb/tb_frac_scaler_dda.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_scaler_dda.sv
// Fractional DDA scaler: restoring-divide setup plus per-line phase engine.
// Define FRAC_SCALER_LIMIT_EN to add the limit_out shift-add multiplier.
module frac_scaler_dda #(
  parameter int BITWIDTH  = 10,
  parameter int FRACWIDTH = 16,
  parameter int COEFWIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BITWIDTH-1:0]  num,
  input  logic [BITWIDTH-1:0]  den,
  input  logic [BITWIDTH-1:0]  limit,
  input  logic                 newfraction,
  output logic                 busy,
  output logic                 ready,
  output logic                 div_zero,
  output logic [BITWIDTH-1:0]  limit_out,
  input  logic                 step_reset,
  input  logic                 step_in,
  input  logic [FRACWIDTH-1:0] step_offset,
  input  logic [BITWIDTH-1:0]  centre_offset,
  output logic                 step_out,
  output logic [1:0]           advance,
  output logic [BITWIDTH-1:0]  whole,
  output logic [FRACWIDTH-1:0] fraction,
  output logic [COEFWIDTH-1:0] coef,
  output logic                 blank
);

  localparam int W  = BITWIDTH + FRACWIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_MUL
  } state_e;

  state_e               state_q, state_d;
  logic [W-1:0]         dq_q, dq_d;
  logic [BITWIDTH-1:0]  rem_q, rem_d;
  logic [BITWIDTH-1:0]  den_q, den_d;
  logic [BITWIDTH-1:0]  lim_q, lim_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 dz_q, dz_d;
  logic [W-1:0]         spos_q, spos_d;
  logic [BITWIDTH-1:0]  dpos_q, dpos_d;
  logic [BITWIDTH-1:0]  whole_q, whole_d;
  logic [BITWIDTH-1:0]  offset_q, offset_d;
  logic [FRACWIDTH-1:0] frac_q, frac_d;
  logic [COEFWIDTH-1:0] coef_q, coef_d;
  logic [1:0]           adv_q, adv_d;
  logic                 sout_q, sout_d;
`ifdef FRAC_SCALER_LIMIT_EN
  logic [W+BITWIDTH-1:0] acc_q, acc_d;
  logic [W+BITWIDTH-1:0] mcand_q, mcand_d;
  logic [BITWIDTH-1:0]   mlim_q, mlim_d;
  logic [BITWIDTH-1:0]   limo_q, limo_d;
`endif

  logic [BITWIDTH:0]   rem_sh;
  logic                rem_ge;
  logic [BITWIDTH-1:0] sw;
  logic [BITWIDTH-1:0] diff;
  logic                fwd;
  logic [W-1:0]        spos_nx;
  logic [1:0]          adv_nx;
  logic                init;

  // dq_q shifts the dividend out and the quotient in; it holds step once done
  assign rem_sh  = {rem_q, dq_q[W-1]};
  assign rem_ge  = rem_sh >= {1'b0, den_q};
  assign sw      = spos_q[W-1:FRACWIDTH];
  assign diff    = dpos_q - sw;
  assign fwd     = dpos_q > sw;
  assign spos_nx = spos_q + dq_q;
  assign adv_nx  = (diff > BITWIDTH'(3)) ? 2'd3 : diff[1:0];
  assign init    = step_reset || newfraction;

  always_comb begin
    state_d  = state_q;
    dq_d     = dq_q;
    rem_d    = rem_q;
    den_d    = den_q;
    lim_d    = lim_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    dz_d     = dz_q;
    spos_d   = spos_q;
    dpos_d   = dpos_q;
    whole_d  = whole_q;
    offset_d = offset_q;
    frac_d   = frac_q;
    coef_d   = coef_q;
    adv_d    = adv_q;
    sout_d   = 1'b0;
`ifdef FRAC_SCALER_LIMIT_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mlim_d   = mlim_q;
    limo_d   = limo_q;
`endif

    case (state_q)
      S_DIV: begin
        rem_d = rem_ge ? BITWIDTH'(rem_sh - {1'b0, den_q})
                       : rem_sh[BITWIDTH-1:0];
        dq_d  = {dq_q[W-2:0], rem_ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
`ifdef FRAC_SCALER_LIMIT_EN
          state_d = S_MUL;
          cnt_d   = CW'(BITWIDTH);
          acc_d   = '0;
          mcand_d = {{BITWIDTH{1'b0}}, dq_d};
          mlim_d  = lim_q;
`else
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
`endif
        end
      end
`ifdef FRAC_SCALER_LIMIT_EN
      S_MUL: begin
        if (mlim_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mlim_d  = mlim_q >> 1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          limo_d  = acc_d[FRACWIDTH +: BITWIDTH];
        end
      end
`endif
      default: ;
    endcase

    if (newfraction) begin
      state_d = S_DIV;
      busy_d  = 1'b1;
      ready_d = 1'b0;
      dz_d    = (den == '0);
      den_d   = den;
      lim_d   = limit;
      dq_d    = {num, {FRACWIDTH{1'b0}}};
      rem_d   = '0;
      cnt_d   = CW'(W);
    end

    if (init) begin
      spos_d   = {{BITWIDTH{1'b0}}, step_offset};
      dpos_d   = '0;
      whole_d  = '0;
      offset_d = centre_offset;
    end else if (ready_q) begin
      if (step_in) begin
        if (offset_q != '0) begin
          offset_d = offset_q - BITWIDTH'(1);
          frac_d   = '0;
          coef_d   = '0;
        end else begin
          if (fwd) begin
            spos_d  = spos_nx;
            sout_d  = 1'b1;
            adv_d   = adv_nx;
            whole_d = whole_q + {{(BITWIDTH-2){1'b0}}, adv_nx};
            frac_d  = spos_nx[FRACWIDTH-1:0];
            coef_d  = spos_nx[FRACWIDTH-1 -: COEFWIDTH];
          end else begin
            frac_d = '0;
            coef_d = '0;
          end
          if (diff < BITWIDTH'(2)) dpos_d = dpos_q + BITWIDTH'(1);
        end
      end
      // past the line end: hold the engine in blanking
      if (whole_d >= lim_q) offset_d = '1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      dq_q     <= '0;
      rem_q    <= '0;
      den_q    <= '0;
      lim_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      dz_q     <= 1'b0;
      spos_q   <= '0;
      dpos_q   <= '0;
      whole_q  <= '0;
      offset_q <= '0;
      frac_q   <= '0;
      coef_q   <= '0;
      adv_q    <= '0;
      sout_q   <= 1'b0;
`ifdef FRAC_SCALER_LIMIT_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mlim_q   <= '0;
      limo_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      dq_q     <= dq_d;
      rem_q    <= rem_d;
      den_q    <= den_d;
      lim_q    <= lim_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      dz_q     <= dz_d;
      spos_q   <= spos_d;
      dpos_q   <= dpos_d;
      whole_q  <= whole_d;
      offset_q <= offset_d;
      frac_q   <= frac_d;
      coef_q   <= coef_d;
      adv_q    <= adv_d;
      sout_q   <= sout_d;
`ifdef FRAC_SCALER_LIMIT_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mlim_q   <= mlim_d;
      limo_q   <= limo_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign ready    = ready_q;
  assign div_zero = dz_q;
  assign step_out = sout_q;
  assign advance  = adv_q;
  assign whole    = whole_q;
  assign fraction = frac_q;
  assign coef     = coef_q;
  assign blank    = |offset_q;
`ifdef FRAC_SCALER_LIMIT_EN
  assign limit_out = limo_q;
`else
  assign limit_out = '0;
`endif

endmodule

// File: tb/tb_frac_scaler_dda.sv
// Bench for frac_scaler_dda: directed scenarios plus a randomized
// comparison against a position-arithmetic model of the line engine.
module tb_frac_scaler_dda;

  localparam int BW = 10;
  localparam int FW = 16;
  localparam int CF = 4;
  localparam int W  = BW + FW;
`ifdef FRAC_SCALER_LIMIT_EN
  localparam int LAT    = W + BW + 1;
  localparam bit LIM_EN = 1'b1;
`else
  localparam int LAT    = W + 1;
  localparam bit LIM_EN = 1'b0;
`endif
  localparam longint WMASK = (64'd1 << W) - 1;

  logic          clk;
  logic          reset_n;
  logic [BW-1:0] num, den, limit;
  logic          newfraction;
  logic          busy, ready, div_zero;
  logic [BW-1:0] limit_out;
  logic          step_reset, step_in;
  logic [FW-1:0] step_offset;
  logic [BW-1:0] centre_offset;
  logic          step_out;
  logic [1:0]    advance;
  logic [BW-1:0] whole;
  logic [FW-1:0] fraction;
  logic [CF-1:0] coef;
  logic          blank;

  int n_chk = 0;
  int n_fail = 0;

  // model state: source position in W-bit fixed point, dest counter
  longint m_step, m_sp;
  int     m_lim, m_dp, m_wh, m_off, m_adv, m_frac, m_coef;
  bit     m_sout, m_dz;

  frac_scaler_dda dut (
    .clk(clk), .reset_n(reset_n),
    .num(num), .den(den), .limit(limit),
    .newfraction(newfraction),
    .busy(busy), .ready(ready), .div_zero(div_zero),
    .limit_out(limit_out),
    .step_reset(step_reset), .step_in(step_in),
    .step_offset(step_offset),
    .centre_offset(centre_offset),
    .step_out(step_out), .advance(advance),
    .whole(whole), .fraction(fraction),
    .coef(coef), .blank(blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic m_line_init();
    m_sp   = longint'(step_offset);
    m_dp   = 0;
    m_wh   = 0;
    m_off  = int'(centre_offset);
    m_sout = 1'b0;
  endtask

  task automatic m_setup();
    if (den == 0) m_step = WMASK;
    else m_step = (longint'(num) << FW) / longint'(den);
    m_lim = int'(limit);
    m_dz  = (den == 0);
    m_line_init();
  endtask

  task automatic m_clock(input bit rs, input bit si);
    int srcw, gap, a;
    if (rs) begin
      m_line_init();
      return;
    end
    m_sout = 1'b0;
    if (si) begin
      if (m_off != 0) begin
        m_off--;
        m_frac = 0;
        m_coef = 0;
      end else begin
        srcw = int'(m_sp >> FW);
        gap  = (m_dp - srcw) & 1023;
        if (m_dp > srcw) begin
          m_sp   = (m_sp + m_step) & WMASK;
          m_sout = 1'b1;
          a      = (gap > 3) ? 3 : gap;
          m_adv  = a;
          m_wh   = (m_wh + a) & 1023;
          m_frac = int'(m_sp & 64'hFFFF);
          m_coef = m_frac >> (FW - CF);
        end else begin
          m_frac = 0;
          m_coef = 0;
        end
        if (gap < 2) m_dp = (m_dp + 1) & 1023;
      end
    end
    if (m_wh >= m_lim) m_off = 1023;
  endtask

  task automatic run_setup(output int cyc);
    newfraction = 1'b1;
    @(posedge clk); #1;
    newfraction = 1'b0;
    cyc = 1;
    while (!ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!ready) cyc = -1;
  endtask

  task automatic pulse_reset_line();
    step_reset = 1'b1;
    @(posedge clk); #1;
    step_reset = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    reset_n = 1'b0;
    #12;
    n_chk++;
    if ({ready, busy, div_zero, step_out} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 0000",
               {ready, busy, div_zero, step_out});
    end
    n_chk++;
    if ({advance, whole, fraction, coef, blank, limit_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h exp 0",
               {advance, whole, fraction, coef, blank, limit_out});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready) seen++;
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL ready_idle got %0d ready cycles exp 0", seen);
    end
  endtask

  task automatic test_setup_latency();
    int cyc, rc, nb;
    num = 10'd2; den = 10'd1; limit = 10'd100;
    run_setup(cyc);
    newfraction = 1'b1;
    @(posedge clk); #1;
    newfraction = 1'b0;
    n_chk++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_fall got %b exp 0", ready);
    end
    rc = -1; nb = 0;
    for (int c = 1; c < 80; c++) begin
      if (ready && rc < 0) rc = c;
      if (rc < 0 && busy) nb++;
      if (rc < 0) begin
        @(posedge clk); #1;
      end
    end
    n_chk++;
    if (rc !== LAT) begin
      n_fail++;
      $display("FAIL ready_cycle got %0d exp %0d", rc, LAT);
    end
    n_chk++;
    if (nb !== LAT - 1) begin
      n_fail++;
      $display("FAIL busy_len got %0d exp %0d", nb, LAT - 1);
    end
    n_chk++;
    if ({busy, div_zero} !== 2'b00) begin
      n_fail++;
      $display("FAIL done_flags got %b exp 00", {busy, div_zero});
    end
    n_chk++;
    if (limit_out !== (LIM_EN ? 10'd200 : 10'd0)) begin
      n_fail++;
      $display("FAIL limit_out got %0d exp %0d",
               limit_out, LIM_EN ? 200 : 0);
    end
  endtask

  task automatic test_dda_basic();
    int cyc;
    num = 10'd2; den = 10'd1; limit = 10'd100;
    step_offset = '0; centre_offset = '0;
    run_setup(cyc);
    pulse_reset_line();
    for (int i = 1; i <= 8; i++) begin
      step_in = 1'b1;
      @(posedge clk); #1;
      step_in = 1'b0;
      n_chk++;
      if (step_out !== ((i % 2) == 0)) begin
        n_fail++;
        $display("FAIL dda_out%0d got %b exp %b",
                 i, step_out, (i % 2) == 0);
      end
      if ((i % 2) == 0) begin
        n_chk++;
        if (advance !== 2'd1) begin
          n_fail++;
          $display("FAIL dda_adv%0d got %0d exp 1", i, advance);
        end
      end
    end
    n_chk++;
    if (whole !== 10'd4) begin
      n_fail++;
      $display("FAIL dda_whole got %0d exp 4", whole);
    end
  endtask

  task automatic test_centre_offset();
    int cyc;
    num = 10'd2; den = 10'd1; limit = 10'd100;
    step_offset = '0; centre_offset = 10'd3;
    run_setup(cyc);
    for (int i = 1; i <= 3; i++) begin
      n_chk++;
      if (blank !== 1'b1) begin
        n_fail++;
        $display("FAIL centre_blank%0d got %b exp 1", i, blank);
      end
      step_in = 1'b1;
      @(posedge clk); #1;
      step_in = 1'b0;
      n_chk++;
      if (step_out !== 1'b0) begin
        n_fail++;
        $display("FAIL centre_out%0d got %b exp 0", i, step_out);
      end
    end
    n_chk++;
    if (blank !== 1'b0) begin
      n_fail++;
      $display("FAIL centre_done got %b exp 0", blank);
    end
    centre_offset = '0;
  endtask

  task automatic test_limit_blank();
    int cyc;
    num = 10'd1; den = 10'd1; limit = 10'd2;
    step_offset = '0; centre_offset = '0;
    run_setup(cyc);
    pulse_reset_line();
    for (int i = 1; i <= 10; i++) begin
      step_in = 1'b1;
      @(posedge clk); #1;
      step_in = 1'b0;
      if (i >= 3) begin
        n_chk++;
        if ({blank, whole} !== {1'b1, 10'd2}) begin
          n_fail++;
          $display("FAIL limit_blank%0d got %b/%0d exp 1/2",
                   i, blank, whole);
        end
      end
      if (i >= 4) begin
        n_chk++;
        if (step_out !== 1'b0) begin
          n_fail++;
          $display("FAIL limit_out%0d got %b exp 0", i, step_out);
        end
      end
    end
    pulse_reset_line();
    n_chk++;
    if ({blank, whole} !== {1'b0, 10'd0}) begin
      n_fail++;
      $display("FAIL limit_rst got %b/%0d exp 0/0", blank, whole);
    end
  endtask

  task automatic test_div_zero();
    int cyc, seen;
    num = 10'd5; den = 10'd0; limit = 10'd100;
    step_offset = '0; centre_offset = '0;
    run_setup(cyc);
    n_chk++;
    if (div_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_flag got %b exp 1", div_zero);
    end
    pulse_reset_line();
    step_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    step_in = 1'b0;
    n_chk++;
    if ({step_out, fraction, coef} !== {1'b1, 16'hFFFF, 4'hF}) begin
      n_fail++;
      $display("FAIL dz_step got %b/%h/%h exp 1/ffff/f",
               step_out, fraction, coef);
    end
    newfraction = 1'b1;
    @(posedge clk); #1;
    newfraction = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({ready, busy, div_zero} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset got %b exp 000",
               {ready, busy, div_zero});
    end
    #2;
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready || busy) seen++;
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL post_reset got %0d active cycles exp 0", seen);
    end
  endtask

  task automatic test_abort();
    int cyc;
    num = 10'd7; den = 10'd0; limit = 10'd100;
    step_offset = '0; centre_offset = '0;
    newfraction = 1'b1;
    @(posedge clk); #1;
    newfraction = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    num = 10'd3; den = 10'd2;
    run_setup(cyc);
    n_chk++;
    if (cyc !== LAT) begin
      n_fail++;
      $display("FAIL abort_lat got %0d exp %0d", cyc, LAT);
    end
    n_chk++;
    if (div_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_dz got %b exp 0", div_zero);
    end
    pulse_reset_line();
    step_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    step_in = 1'b0;
    n_chk++;
    if ({step_out, fraction, coef} !== {1'b1, 16'h8000, 4'h8}) begin
      n_fail++;
      $display("FAIL abort_step got %b/%h/%h exp 1/8000/8",
               step_out, fraction, coef);
    end
  endtask

  task automatic test_random();
    int cyc;
    bit rs, si;
    logic [33:0] got, exp;
    logic [BW-1:0] exp_lo;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    m_adv = 0; m_frac = 0; m_coef = 0; m_sout = 1'b0;
    for (int k = 0; k < 8; k++) begin
      num = BW'($urandom_range(1, 1023));
      den = ($urandom_range(0, 5) == 0) ? '0
            : BW'($urandom_range(1, 1023));
      limit = BW'($urandom_range(0, 48));
      step_offset = FW'($urandom);
      centre_offset = BW'($urandom_range(0, 4));
      m_setup();
      run_setup(cyc);
      n_chk++;
      if (cyc !== LAT) begin
        n_fail++;
        $display("FAIL rnd_lat%0d got %0d exp %0d", k, cyc, LAT);
      end
      exp_lo = LIM_EN ? BW'((m_step * m_lim) >> FW) : '0;
      n_chk++;
      if ({div_zero, limit_out} !== {m_dz, exp_lo}) begin
        n_fail++;
        $display("FAIL rnd_cfg%0d got %b/%0d exp %b/%0d",
                 k, div_zero, limit_out, m_dz, exp_lo);
      end
      for (int c = 0; c < 80; c++) begin
        rs = ($urandom_range(0, 19) == 0);
        si = ($urandom_range(0, 3) != 0);
        step_reset = rs;
        step_in = si;
        @(posedge clk); #1;
        step_reset = 1'b0;
        step_in = 1'b0;
        m_clock(rs, si);
        got = {step_out, advance, whole, fraction, coef, blank};
        exp = {m_sout, 2'(m_adv), 10'(m_wh), 16'(m_frac),
               4'(m_coef), (m_off != 0)};
        n_chk++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL rnd_line cfg%0d cyc%0d got %h exp %h",
                   k, c, got, exp);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    num = '0; den = '0; limit = '0;
    newfraction = 1'b0;
    step_reset = 1'b0; step_in = 1'b0;
    step_offset = '0; centre_offset = '0;
    test_reset();
    test_setup_latency();
    test_dda_basic();
    test_centre_offset();
    test_limit_blank();
    test_div_zero();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
